// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and the byte-strobe merge used by register slaves.
package axil_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    axi_resp_t                 resp;
  } axil_rsp_t;

  function automatic logic [AXI_DATA_WIDTH-1:0] strb_merge(
    input logic [AXI_DATA_WIDTH-1:0] old_v,
    input logic [AXI_DATA_WIDTH-1:0] new_v,
    input logic [AXI_STRB_WIDTH-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < AXI_STRB_WIDTH; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction
endpackage

// File: rtl/axil_slave_regfile.sv
// AXI-Lite register file: one-deep AW/W buffers, strobed commit with B response,
// single-cycle registered reads; register 0 is a read-only ID.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [AXI_DATA_WIDTH-1:0] regs_out [NUM_REGS],
  output logic [NUM_REGS-1:0]       reg_wr_stb
);
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] NREGS_A = AXI_ADDR_WIDTH'(NUM_REGS);
  localparam logic [AXI_DATA_WIDTH-1:0] ID_W    = AXI_DATA_WIDTH'(ID_VALUE);

  // ---------------- write path ----------------
  logic                      aw_full_q, w_full_q, bvalid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_STRB_WIDTH-1:0] wstrb_q;
  axi_resp_t                 bresp_q;
  logic [NUM_REGS-1:0]       wr_stb_q;
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [AXI_ADDR_WIDTH-1:0] wa_full;
  logic [IDX_W-1:0]          wa_idx;
  logic                      commit, wa_ok;
  logic [NUM_REGS-1:0]       wa_oh_d;
  logic [AXI_DATA_WIDTH-1:0] wreg_d;

  // Range check uses the full-width index so aliased high addresses are rejected.
  assign wa_full = awaddr_q >> ADDR_LSB;
  assign wa_idx  = wa_full[IDX_W-1:0];
  assign commit  = aw_full_q && w_full_q && !bvalid_q;
  assign wa_ok   = (wa_full < NREGS_A) && (wa_full != '0);
  assign wa_oh_d = (commit && wa_ok) ? (NUM_REGS'(1) << wa_idx) : '0;
  assign wreg_d  = strb_merge(regs_q[wa_idx], wdata_q, wstrb_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      wr_stb_q  <= '0;
      regs_q[0] <= ID_W;
      for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_stb_q <= wa_oh_d;
      if (s_axil_awvalid && !aw_full_q) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr;
      end
      if (s_axil_wvalid && !w_full_q) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end
      if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      // commit needs both flags set, so it never collides with a new handshake
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wa_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
      for (int k = 1; k < NUM_REGS; k++)
        if (wa_oh_d[k]) regs_q[k] <= wreg_d;
    end
  end

  // ---------------- read path ----------------
  logic                      rvalid_q;
  axil_rsp_t                 rd_q, rd_d;
  logic [AXI_ADDR_WIDTH-1:0] ra_full;
  logic [IDX_W-1:0]          ra_idx;

  assign ra_full = s_axil_araddr >> ADDR_LSB;
  assign ra_idx  = ra_full[IDX_W-1:0];

  always_comb begin
    rd_d = '{data: '0, resp: AXI_RESP_SLVERR};
    if (ra_full < NREGS_A) rd_d = '{data: regs_q[ra_idx], resp: AXI_RESP_OKAY};
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_q <= 1'b0;
      rd_q     <= '0;
    end else if (s_axil_arvalid && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rd_q     <= rd_d;
    end else if (s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil_awready = !aw_full_q;
  assign s_axil_wready  = !w_full_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rd_q.data;
  assign s_axil_rresp   = rd_q.resp;
  assign regs_out       = regs_q;
  assign reg_wr_stb     = wr_stb_q;
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: stimulus pushes expected B/R/strobe
// events, a forked monitor pops and compares them as the DUT presents them.
module tb_axil_slave_regfile;
  import axil_pkg::*;
  localparam int          NR  = 16;
  localparam logic [31:0] IDV = 32'hA11E_0001;

  logic                      aclk, areset;
  logic [AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic                      awvalid, awready, wvalid, wready, bvalid, bready;
  logic                      arvalid, arready, rvalid, rready;
  logic [AXI_DATA_WIDTH-1:0] wdata, rdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic [1:0]                bresp, rresp;
  logic [AXI_DATA_WIDTH-1:0] regs_out [NR];
  logic [NR-1:0]             reg_wr_stb;

  axil_slave_regfile #(.NUM_REGS(NR), .ID_VALUE(IDV)) dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .regs_out(regs_out), .reg_wr_stb(reg_wr_stb)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  int          exp_stb[$];
  logic [31:0] model [NR];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no DUT response within budget, expected one", nm);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model[k] = (k == 0) ? IDV : 32'h0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (bvalid && bready) begin
          if (exp_b.size() == 0) timeout("b_unexpected");
          else begin
            logic [1:0] e;
            e = exp_b.pop_front();
            chk("bresp", 32'(bresp), 32'(e));
          end
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) timeout("r_unexpected");
          else begin
            rexp_t e;
            e = exp_r.pop_front();
            chk("rdata", rdata, e.data);
            chk("rresp", 32'(rresp), 32'(e.resp));
          end
        end
        if (reg_wr_stb != '0) begin
          if (exp_stb.size() == 0) timeout("stb_unexpected");
          else begin
            int i;
            i = exp_stb.pop_front();
            chk("wr_stb", 32'(reg_wr_stb), 32'(1) << i);
          end
        end
      end
    end
  endtask

  task automatic drive_aw(input logic [31:0] a, input int dly);
    bit hs;
    repeat (dly) begin @(posedge aclk); #1; end
    awaddr = a; awvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      hs = awready;
      @(posedge aclk); #1;
      if (hs) begin awvalid = 1'b0; return; end
    end
    awvalid = 1'b0;
    timeout("aw_handshake");
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs;
    repeat (dly) begin @(posedge aclk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      hs = wready;
      @(posedge aclk); #1;
      if (hs) begin wvalid = 1'b0; return; end
    end
    wvalid = 1'b0;
    timeout("w_handshake");
  endtask

  // Expected effect comes from the register-map rules: bytes with strobe set take new data.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int daw, input int dw, input bit lat);
    int idx;
    idx = int'(a >> 2);
    if (idx >= 1 && idx < NR) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx] = (model[idx] & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      exp_b.push_back(AXI_RESP_OKAY);
      exp_stb.push_back(idx);
    end else begin
      exp_b.push_back(AXI_RESP_SLVERR);
    end
    fork
      drive_aw(a, daw);
      drive_w(d, s, dw);
    join
    if (lat) begin
      chk("b_early", 32'(bvalid), 32'd0);
      @(posedge aclk); #1;
      chk("b_latency", 32'(bvalid), 32'd1);
      if (idx >= 1 && idx < NR) chk("reg_after_commit", regs_out[idx], model[idx]);
    end
  endtask

  task automatic rd_exp(input logic [31:0] a, input int dly, input logic [31:0] ed, input logic [1:0] er);
    rexp_t e;
    bit hs;
    e.data = ed; e.resp = er;
    exp_r.push_back(e);
    repeat (dly) begin @(posedge aclk); #1; end
    araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      hs = arready;
      @(posedge aclk); #1;
      if (hs) begin
        arvalid = 1'b0;
        chk("r_latency", 32'(rvalid), 32'd1);
        return;
      end
    end
    arvalid = 1'b0;
    timeout("ar_handshake");
  endtask

  task automatic rd(input logic [31:0] a, input int dly);
    int idx;
    idx = int'(a >> 2);
    if (idx < NR) rd_exp(a, dly, model[idx], AXI_RESP_OKAY);
    else          rd_exp(a, dly, 32'h0, AXI_RESP_SLVERR);
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0 && exp_stb.size() == 0) return;
      @(posedge aclk); #1;
    end
    timeout("drain");
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    model_reset();
    fork monitor(); join_none
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_stb", 32'(reg_wr_stb), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    for (int k = 0; k < NR; k++) chk("rst_regs", regs_out[k], model[k]);
    areset = 1'b0;
    @(posedge aclk); #1;

    // AW one cycle ahead of W, then read back
    wr(32'h04, 32'hDEADBEEF, 4'hF, 0, 1, 1);
    drain();
    rd(32'h04, 0);
    drain();

    // partial strobe over an all-ones register
    wr(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
    drain();
    wr(32'h08, 32'h11223344, 4'b0101, 1, 0, 1);
    drain();
    chk("strobe_merge", regs_out[2], 32'hFF22FF44);
    rd(32'h08, 0);
    drain();

    // ID register is read-only, out-of-range read errors
    wr(32'h00, 32'h12345678, 4'hF, 0, 0, 1);
    drain();
    chk("id_readonly", regs_out[0], IDV);
    rd(32'h00, 0);
    rd(32'h40, 0);
    drain();

    // B back-pressure: second pair buffers, third stalls
    bready = 1'b0;
    wr(32'h10, 32'hA5A50001, 4'hF, 0, 0, 1);
    wr(32'h00, 32'h0, 4'hF, 0, 0, 0);
    chk("bp_awready", 32'(awready), 32'd0);
    chk("bp_wready", 32'(wready), 32'd0);
    fork
      wr(32'h14, 32'h00005A5A, 4'h3, 0, 0, 0);
    join_none
    repeat (4) begin @(posedge aclk); #1; end
    chk("stall_awready", 32'(awready), 32'd0);
    chk("stall_wready", 32'(wready), 32'd0);
    chk("stall_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    drain();
    rd(32'h10, 0);
    rd(32'h14, 0);
    drain();

    // read and commit on the same edge see the old value
    wr(32'h0C, 32'h1, 4'hF, 0, 0, 1);
    drain();
    fork
      wr(32'h0C, 32'h2, 4'hF, 0, 0, 0);
      rd_exp(32'h0C, 1, 32'h1, AXI_RESP_OKAY);
    join
    drain();
    rd(32'h0C, 0);
    drain();

    // randomized writes and reads, including ignored low bits and out-of-range indices
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      wr(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
      drain();
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      rd(a, int'($urandom_range(0, 2)));
      drain();
    end

    // reset with B and R both pending
    bready = 1'b0;
    rready = 1'b0;
    wr(32'h18, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    rd(32'h18, 0);
    #2;
    areset = 1'b1;
    #1;
    chk("rst_async_bvalid", 32'(bvalid), 32'd0);
    chk("rst_async_rvalid", 32'(rvalid), 32'd0);
    chk("rst_async_awready", 32'(awready), 32'd1);
    chk("rst_async_rdata", rdata, 32'd0);
    exp_b.delete();
    exp_r.delete();
    exp_stb.delete();
    model_reset();
    @(posedge aclk); #1;
    areset = 1'b0;
    bready = 1'b1;
    rready = 1'b1;
    @(posedge aclk); #1;
    for (int k = 0; k < NR; k++) rd(32'(k) << 2, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
